// File: rtl/bus_reg_file.sv
//------------------------------------------------------------------------------
// Module   : bus_reg_file
// Purpose  : Bank of DEPTH general-purpose WIDTH-bit registers on the tri-state bus.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_reg_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  inout  wire  [WIDTH-1:0]       bus,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic                   data_in,
  input  logic                   data_out,
  input  logic                   clr,
  input  logic                   inc,
  input  logic                   err_clr,
  output logic                   carry,
  output logic                   zero,
  output logic                   err,
  output logic [WIDTH*DEPTH-1:0] reg_view
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] rd_cur;
  logic             wr_ok;
  logic             rd_ok;
  logic             wr_act;
  logic             addr_err;

  assign wr_ok    = {{(32-ADDR_W){1'b0}}, wr_addr} < 32'(DEPTH);
  assign rd_ok    = {{(32-ADDR_W){1'b0}}, rd_addr} < 32'(DEPTH);
  assign wr_act   = clr | data_in | inc;
  assign addr_err = (wr_act & ~wr_ok) | (data_out & ~rd_ok);

  always_comb begin
    wr_cur = '0;
    rd_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_cur = regs[i];
      if (rd_addr == ADDR_W'(i)) rd_cur = regs[i];
    end
  end

  // Bus is released while reset is held, whatever data_out says.
  assign bus  = (reset && data_out && rd_ok) ? rd_cur : 'z;
  assign zero = rd_ok && (rd_cur == '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    assign reg_view[g*WIDTH +: WIDTH] = regs[g];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && wr_addr == ADDR_W'(i)) begin
          if (clr)          regs[i] <= '0;
          else if (data_in) regs[i] <= bus;
          else if (inc)     regs[i] <= regs[i] + WIDTH'(1);
        end
      end
      if (wr_ok && inc && !clr && !data_in) carry <= &wr_cur;
      if (addr_err)     err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_reg_file.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_reg_file
// Purpose  : Scoreboard bench for bus_reg_file in three parameter configurations.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_addr, rd_addr;
  logic        data_in, data_out, clr, inc, err_clr;
  logic        drv_en;
  logic [15:0] drv_val;

  wire  [7:0]  bus_a, bus_b;
  wire  [15:0] bus_c;
  logic        carry_a, zero_a, err_a;
  logic        carry_b, zero_b, err_b;
  logic        carry_c, zero_c, err_c;
  logic [31:0] view_a;
  logic [23:0] view_b;
  logic [63:0] view_c;

  assign bus_a = drv_en ? drv_val[7:0] : 'z;
  assign bus_b = drv_en ? drv_val[7:0] : 'z;
  assign bus_c = drv_en ? drv_val      : 'z;

  always #5 clk = ~clk;

  bus_reg_file #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .data_in(data_in), .data_out(data_out), .clr(clr), .inc(inc), .err_clr(err_clr),
    .carry(carry_a), .zero(zero_a), .err(err_a), .reg_view(view_a));

  bus_reg_file #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .data_in(data_in), .data_out(data_out), .clr(clr), .inc(inc), .err_clr(err_clr),
    .carry(carry_b), .zero(zero_b), .err(err_b), .reg_view(view_b));

  bus_reg_file #(.WIDTH(16), .DEPTH(4), .ADDR_W(2)) u_c (
    .clk(clk), .reset(reset), .bus(bus_c), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .data_in(data_in), .data_out(data_out), .clr(clr), .inc(inc), .err_clr(err_clr),
    .carry(carry_c), .zero(zero_c), .err(err_c), .reg_view(view_c));

  // Selector codes: tens digit picks the instance, units digit the output.
  localparam int BUS = 0, VIEW = 1, CARRY = 2, ZERO = 3, ERR = 4;
  localparam int A = 0, B = 10, C = 20;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] actual(int sel);
    case (sel)
      A+BUS:   return 64'(bus_a);
      A+VIEW:  return 64'(view_a);
      A+CARRY: return 64'(carry_a);
      A+ZERO:  return 64'(zero_a);
      A+ERR:   return 64'(err_a);
      B+BUS:   return 64'(bus_b);
      B+VIEW:  return 64'(view_b);
      B+CARRY: return 64'(carry_b);
      B+ZERO:  return 64'(zero_b);
      B+ERR:   return 64'(err_b);
      C+BUS:   return 64'(bus_c);
      C+VIEW:  return view_c;
      C+CARRY: return 64'(carry_c);
      C+ZERO:  return 64'(zero_c);
      default: return 64'(err_c);
    endcase
  endfunction

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] got;
      e   = q.pop_front();
      got = actual(e.sel);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end

  task automatic push(input string n, input int sel, input logic [63:0] v);
    q.push_back('{n, sel, v});
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
    data_in = 0; clr = 0; inc = 0; err_clr = 0; data_out = 0; drv_en = 0;
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] v);
    wr_addr = a; drv_en = 1; drv_val = v; data_in = 1;
    edge_();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; wr_addr = 0; rd_addr = 0; data_in = 0; data_out = 0;
    clr = 0; inc = 0; err_clr = 0; drv_en = 0; drv_val = 0;
    #2 reset = 0;
    push("rst_view_a", A+VIEW, 0);  push("rst_carry_a", A+CARRY, 0);
    push("rst_err_a", A+ERR, 0);    push("rst_zero_a", A+ZERO, 1);
    drain();
    reset = 1;

    // Load from bus, then drive it back
    load(2'd1, 16'h00CD);
    rd_addr = 1; data_out = 1;
    push("a_bus_cd", A+BUS, 64'hCD);
    push("a_view_cd", A+VIEW, 64'h0000CD00);
    push("a_zero_cd", A+ZERO, 0);
    drain();
    data_out = 0;

    // Increment wrap with carry
    load(2'd2, 16'h00FF);
    wr_addr = 2; inc = 1; edge_();
    rd_addr = 2;
    push("a_wrap_view", A+VIEW, 64'h0000CD00);
    push("a_wrap_carry", A+CARRY, 1);
    push("a_wrap_zero", A+ZERO, 1);
    drain();
    wr_addr = 2; inc = 1; edge_();
    push("a_inc_view", A+VIEW, 64'h0001CD00);
    push("a_inc_carry", A+CARRY, 0);
    push("a_inc_zero", A+ZERO, 0);
    drain();

    // Register-to-register move, then self-move
    load(2'd0, 16'h005A);
    rd_addr = 0; data_out = 1; wr_addr = 3; data_in = 1;
    push("a_move_bus", A+BUS, 64'h5A);
    drain();
    edge_();
    push("a_move_view", A+VIEW, 64'h5A01CD5A);
    drain();
    rd_addr = 0; data_out = 1; wr_addr = 0; data_in = 1;
    edge_();
    push("a_self_view", A+VIEW, 64'h5A01CD5A);
    drain();

    // Write priority: clr > data_in > inc
    load(2'd1, 16'h00FF);
    wr_addr = 1; inc = 1; edge_();
    load(2'd1, 16'h0033);
    push("a_r1_33", A+VIEW, 64'h5A01335A);
    push("a_carry_set", A+CARRY, 1);
    drain();
    wr_addr = 1; clr = 1; data_in = 1; inc = 1; drv_en = 1; drv_val = 16'h0077;
    edge_();
    push("a_prio_clr", A+VIEW, 64'h5A01005A);
    push("a_prio_clr_carry", A+CARRY, 1);
    drain();
    wr_addr = 1; data_in = 1; inc = 1; drv_en = 1; drv_val = 16'h0077;
    edge_();
    push("a_prio_load", A+VIEW, 64'h5A01775A);
    push("a_prio_load_carry", A+CARRY, 1);
    drain();

    // DEPTH=3: invalid address handling and sticky err
    reset = 0;
    push("b_rst_view", B+VIEW, 0);
    push("b_rst_err", B+ERR, 0);
    drain();
    reset = 1;
    load(2'd0, 16'h0022);
    push("b_r0", B+VIEW, 64'h000022);
    push("b_err0", B+ERR, 0);
    drain();
    load(2'd3, 16'h0011);
    push("b_bad_wr_view", B+VIEW, 64'h000022);
    push("b_bad_wr_err", B+ERR, 1);
    drain();
    err_clr = 1; edge_();
    push("b_err_clr", B+ERR, 0);
    drain();
    rd_addr = 3; data_out = 1; drv_en = 1; drv_val = 16'h003C;
    push("b_bad_rd_bus", B+BUS, 64'h3C);
    push("b_bad_rd_zero", B+ZERO, 0);
    drain();
    edge_();
    push("b_bad_rd_err", B+ERR, 1);
    drain();
    err_clr = 1; wr_addr = 3; data_in = 1; drv_en = 1; drv_val = 16'h0011;
    edge_();
    push("b_set_over_clr", B+ERR, 1);
    push("b_set_over_clr_view", B+VIEW, 64'h000022);
    drain();
    err_clr = 1; edge_();
    push("b_err_clr2", B+ERR, 0);
    drain();

    // WIDTH=16: held increment, then asynchronous reset
    reset = 0;
    push("c_rst_view", C+VIEW, 0);
    drain();
    reset = 1;
    load(2'd3, 16'hBEEF);
    wr_addr = 3; inc = 1;
    repeat (3) @(posedge clk);
    #1 inc = 0;
    push("c_hold_inc", C+VIEW, 64'hBEF2_0000_0000_0000);
    push("c_hold_carry", C+CARRY, 0);
    drain();
    load(2'd0, 16'hFFFF);
    wr_addr = 0; inc = 1; edge_();
    push("c_wrap_view", C+VIEW, 64'hBEF2_0000_0000_0000);
    push("c_wrap_carry", C+CARRY, 1);
    drain();
    rd_addr = 3; data_out = 1;
    push("c_bus", C+BUS, 64'hBEF2);
    push("c_zero", C+ZERO, 0);
    drain();
    @(posedge clk);
    #2 reset = 0; drv_en = 1; drv_val = 16'h3C3C;
    push("c_async_view", C+VIEW, 0);
    push("c_async_carry", C+CARRY, 0);
    push("c_async_err", C+ERR, 0);
    push("c_async_zero", C+ZERO, 1);
    push("c_async_bus", C+BUS, 64'h3C3C);
    drain();
    reset = 1; drv_en = 0; data_out = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_reg_file.md
# bus_reg_file

Parametrised bank of general-purpose registers attached to the shared tri-state system bus of the 8-bit computer, generalising the single bus register to DEPTH registers of WIDTH bits. Each cycle one register may be loaded from the bus, cleared or incremented, and one register may drive the bus. It adds wrap-around increment with a carry flag, a zero flag, a sticky address-error flag and a flat debug view of all registers.

## Interface

- WIDTH, 8, register and bus width in bits.
- DEPTH, 4, number of registers (2..256).
- ADDR_W, 2, address width; must satisfy 2^ADDR_W >= DEPTH.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- bus  inout  WIDTH  shared system bus.
- wr_addr  input  ADDR_W  target register for data_in / clr / inc.
- rd_addr  input  ADDR_W  register that drives the bus on data_out.
- data_in  input  1  load wr_addr from bus on next rising edge.
- data_out  input  1  drive regs[rd_addr] onto bus (combinational).
- clr  input  1  synchronous clear of regs[wr_addr].
- inc  input  1  synchronous increment of regs[wr_addr].
- err_clr  input  1  synchronous clear of err.
- carry  output  1  carry out of the most recent accepted inc.
- zero  output  1  1 when regs[rd_addr] == 0 (combinational, 0 for invalid rd_addr).
- err  output  1  sticky: an access used an address >= DEPTH.
- reg_view  output  WIDTH*DEPTH  all registers, reg i at bits [i*WIDTH +: WIDTH].

## Operation

- Reset (reset low, any time, asynchronous): all registers 0, carry 0, err 0. bus released (Z) while reset low regardless of data_out. zero reflects reset contents (1 for valid rd_addr).
- Write-side priority per cycle, for the single register at wr_addr: clr > data_in > inc. Only one action applies.
  - clr: register <= 0; carry unchanged.
  - data_in: register <= bus value sampled at the edge; carry unchanged.
  - inc: register <= register + 1 modulo 2^WIDTH; carry <= 1 if old value was all-ones, else 0.
- Drive side: bus = regs[rd_addr] when data_out=1 and rd_addr < DEPTH, else Z. No internal bus contention check against external drivers; the controller guarantees at most one driver.
- Simultaneous data_out and data_in, same address: bus carries old value, register reloads its own value (no change). Different addresses: register-to-register move in one cycle.
- Simultaneous data_out with clr/inc on the same register: bus carries pre-edge value; register updates at the edge.
- Invalid address (>= DEPTH): write action on wr_addr ignored (no register changes, carry unchanged); data_out on rd_addr leaves bus Z. Either sets err on the next edge.
- err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
- data_in with bus floating (Z/X) loads whatever is sampled; no masking.

## Timing

- Register updates, carry and err: visible one cycle after the edge that samples the strobe (single-cycle latency).
- Bus drive, zero and reg_view: combinational from current register contents and rd_addr/data_out; bus valid in the same cycle data_out rises, released the same cycle it falls.
- Strobes are level-sensitive and act on every rising edge they are high; holding inc for N cycles increments N times.
- Reset deassertion is synchronised externally; block takes no action until the first rising edge with reset high.

## Test plan

- Reset, then bus=0xCD, wr_addr=1, data_in=1 one edge; release bus; rd_addr=1, data_out=1 -> bus reads 0xCD, reg_view[15:8]=0xCD, other registers 0, zero=0.
- Load r2=0xFF, inc on r2 one edge -> r2=0x00, carry=1, zero=1 (rd_addr=2); inc again -> r2=0x01, carry=0.
- r0=0x5A, data_out rd_addr=0 and data_in wr_addr=3 same edge -> r3=0x5A, r0 unchanged; same with wr_addr=0 -> r0 stays 0x5A.
- clr, data_in and inc together on r1 holding 0x33 with bus=0x77 -> r1=0x00; data_in+inc only -> r1=0x77, carry unchanged.
- DEPTH=3, ADDR_W=2: data_in wr_addr=3 with bus=0x11 -> no register changes, err=1; data_out rd_addr=3 -> bus Z; err_clr -> err=0 next cycle; err_clr with another invalid access -> err stays 1.
- WIDTH=16: load 0xBEEF into r3, hold inc 3 cycles -> 0xBEF2; assert reset mid-cycle -> all registers 0, carry 0, err 0, bus Z immediately without a clock edge.
